link_partner: RTL and testbench
===============================

LINK_PARTNER -- requirements
Module: link_partner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 64, master-mode SCK half-period in clk cycles (legal 2..255).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port nreset  input  1  reset; one clock, reset asynchronous, active-low.
REQ-004 SHALL have port sck_dir  input  1  DMG SCK direction; 1 = DMG drives SCK, partner is slave.
REQ-005 SHALL have port sck_in  input  1  SCK level driven by DMG, asynchronous to clk.
REQ-006 SHALL have port sout  input  1  DMG serial data out, asynchronous to clk.
REQ-007 SHALL have port sck_out  output  1  partner-driven SCK, valid when sck_dir=0.
REQ-008 SHALL have port sin_out  output  1  partner serial data to DMG SIN.
REQ-009 SHALL have port tx_byte  input  8  byte the partner sends next.
REQ-010 SHALL have port tx_load  input  1  one-cycle strobe capturing tx_byte into tx_buf.
REQ-011 SHALL have port start  input  1  one-cycle strobe starting a master transfer.
REQ-012 SHALL have port rx_byte  output  8  last completely received byte.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse when rx_byte updates.
REQ-014 SHALL have port busy  output  1  high while a transfer is in progress.

Function
REQ-015 SHALL pass sck_in and sout through 2-flop synchronizers; edges detected on synchronized sck_in vs. its previous value.
REQ-016 SHALL implement FSM states IDLE, SLAVE, M_LOW, M_HIGH; busy=1 in all but IDLE.
REQ-017 SHALL, in IDLE with sck_dir=1, enter SLAVE on a detected SCK falling edge, loading tx_shift from tx_buf and bit count 0 on that same edge.
REQ-018 SHALL, in IDLE with sck_dir=0 and start=1, load tx_shift from tx_buf, clear bit count, drive sck_out=0, enter M_LOW; start ignored while busy.
REQ-019 SHALL, on each SCK falling edge (detected in SLAVE, or entry to M_LOW), set sin_out=tx_shift[7] and shift tx_shift left filling 1 (MSB first).
REQ-020 SHALL, on each SCK rising edge (detected in SLAVE, or entry to M_HIGH), shift synchronized sout into rx_shift LSB and increment 3-bit bit count.
REQ-021 SHALL hold sck_out low for CLK_DIV cycles in M_LOW, then high for CLK_DIV cycles in M_HIGH, repeating 8 periods.
REQ-022 SHALL, on the 8th rising edge, write rx_byte, pulse rx_valid for exactly 1 cycle, return to IDLE with sin_out=1.
REQ-023 SHALL, on tx_load, update tx_buf at any time; a busy transfer keeps its tx_shift, new value used next transfer.
REQ-024 SHALL, when tx_load and transfer start coincide, load the new tx_byte into tx_shift.
REQ-025 SHALL, on sck_dir toggling while busy, abort: return to IDLE, sck_out=1, sin_out=1, no rx_valid, rx_byte unchanged.
REQ-026 SHALL, in SLAVE, tolerate arbitrary SCK period >= 4 clk cycles per level; no timeout.
REQ-027 SHALL hold sck_out=1 whenever not in M_LOW.

Reset
REQ-028 SHALL, on nreset=0, asynchronously force state IDLE, sck_out=1, sin_out=1, rx_byte=8'h00, rx_valid=0, busy=0, tx_buf=8'hFF, tx_shift=8'hFF, rx_shift=0, bit count 0, synchronizers to 1.
REQ-029 SHALL, on reset mid-transfer, discard the partial byte with no rx_valid.

Verification
REQ-030 Slave: tx_load 8'hA5, sck_dir=1, DMG clocks 8 periods sending 8'h3C -> sin_out bits 1,0,1,0,0,1,0,1; rx_byte=8'h3C; one rx_valid pulse.
REQ-031 Master: CLK_DIV=4, tx_load 8'h81, start, loopback sout=sin_out -> 8 sck_out periods of 8 cycles; rx_byte=8'h81; busy high 64 cycles.
REQ-032 tx_load 8'h55 mid-transfer of 8'hF0 -> current byte sent as 8'hF0; next transfer sends 8'h55.
REQ-033 sck_dir toggled after 3 bits -> busy falls, no rx_valid, rx_byte keeps previous value, sck_out=1.
REQ-034 nreset asserted after 5 master bits -> immediate IDLE, sck_out=1, rx_byte=8'h00; next start transfers full 8 bits of 8'hFF.
REQ-035 start while busy -> ignored; exactly 8 SCK periods and one rx_valid.

Source files
------------

// File: rtl/link_partner.sv
// Game Boy link-port partner: shifts one byte each way as SCK slave or SCK master, MSB first.
// Latency: rx_byte/rx_valid 3 clk after the 8th slave SCK rise, or on the 8th master rise.
// Backpressure: none; start is ignored while busy and rx_valid is a one-cycle pulse.
module link_partner #(
    parameter int CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       sck_dir,
    input  logic       sck_in,
    input  logic       sout,
    output logic       sck_out,
    output logic       sin_out,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    input  logic       start,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLAVE  = 2'd1,
        M_LOW  = 2'd2,
        M_HIGH = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic       sck_s1, sck_s2, sck_prev;
    logic       sout_s1, sout_s2;
    logic       sck_fall, sck_rise;
    logic [7:0] tx_buf, tx_buf_nxt;
    logic [7:0] tx_shift, tx_shift_nxt;
    logic [7:0] rx_shift, rx_shift_nxt, rx_shifted;
    logic [7:0] rx_byte_nxt;
    logic [7:0] div_cnt, div_cnt_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       sin_nxt, sck_out_nxt, rx_valid_nxt;

    assign sck_fall   = sck_prev & ~sck_s2;
    assign sck_rise   = ~sck_prev & sck_s2;
    assign rx_shifted = {rx_shift[6:0], sout_s2};
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        tx_buf_nxt   = tx_load ? tx_byte : tx_buf;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        rx_byte_nxt  = rx_byte;
        rx_valid_nxt = 1'b0;
        div_cnt_nxt  = div_cnt;
        bit_cnt_nxt  = bit_cnt;
        sin_nxt      = sin_out;

        case (state)
            IDLE: begin
                // A coincident tx_load is already reflected in tx_buf_nxt.
                if ((sck_dir && sck_fall) || (!sck_dir && start)) begin
                    state_nxt    = sck_dir ? SLAVE : M_LOW;
                    sin_nxt      = tx_buf_nxt[7];
                    tx_shift_nxt = {tx_buf_nxt[6:0], 1'b1};
                    bit_cnt_nxt  = 3'd0;
                    div_cnt_nxt  = 8'd0;
                end
            end
            SLAVE: begin
                if (!sck_dir) begin
                    state_nxt = IDLE;
                    sin_nxt   = 1'b1;
                end else if (sck_fall) begin
                    sin_nxt      = tx_shift[7];
                    tx_shift_nxt = {tx_shift[6:0], 1'b1};
                end else if (sck_rise) begin
                    rx_shift_nxt = rx_shifted;
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte_nxt  = rx_shifted;
                        rx_valid_nxt = 1'b1;
                        state_nxt    = IDLE;
                        sin_nxt      = 1'b1;
                    end
                end
            end
            M_LOW: begin
                if (sck_dir) begin
                    state_nxt = IDLE;
                    sin_nxt   = 1'b1;
                end else if (div_cnt == DIV_LAST) begin
                    state_nxt    = M_HIGH;
                    div_cnt_nxt  = 8'd0;
                    rx_shift_nxt = rx_shifted;
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte_nxt  = rx_shifted;
                        rx_valid_nxt = 1'b1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end
            M_HIGH: begin
                // bit_cnt has wrapped to 0 only after the 8th rising edge.
                if (sck_dir) begin
                    state_nxt = IDLE;
                    sin_nxt   = 1'b1;
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = 8'd0;
                    if (bit_cnt == 3'd0) begin
                        state_nxt = IDLE;
                        sin_nxt   = 1'b1;
                    end else begin
                        state_nxt    = M_LOW;
                        sin_nxt      = tx_shift[7];
                        tx_shift_nxt = {tx_shift[6:0], 1'b1};
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                sin_nxt   = 1'b1;
            end
        endcase

        sck_out_nxt = (state_nxt != M_LOW);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            sck_s1   <= 1'b1;
            sck_s2   <= 1'b1;
            sck_prev <= 1'b1;
            sout_s1  <= 1'b1;
            sout_s2  <= 1'b1;
            tx_buf   <= 8'hFF;
            tx_shift <= 8'hFF;
            rx_shift <= 8'h00;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
            div_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
            sin_out  <= 1'b1;
            sck_out  <= 1'b1;
        end else begin
            state    <= state_nxt;
            sck_s1   <= sck_in;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            sout_s1  <= sout;
            sout_s2  <= sout_s1;
            tx_buf   <= tx_buf_nxt;
            tx_shift <= tx_shift_nxt;
            rx_shift <= rx_shift_nxt;
            rx_byte  <= rx_byte_nxt;
            rx_valid <= rx_valid_nxt;
            div_cnt  <= div_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            sin_out  <= sin_nxt;
            sck_out  <= sck_out_nxt;
        end
    end

endmodule

// File: tb/tb_link_partner.sv
// Directed bench for link_partner with CLK_DIV=4: slave, master loopback, tx_load timing, abort, reset, start-while-busy.
module tb_link_partner;

    logic       clk = 1'b0;
    logic       nreset, sck_dir, sck_in, sout_drv, loop_en, tx_load, start;
    logic [7:0] tx_byte;
    wire        sout;
    logic       sck_out, sin_out, rx_valid, busy;
    logic [7:0] rx_byte;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;
    int sck_falls = 0;
    int rxv_cnt = 0;
    logic sck_prev = 1'b1;

    always #5 clk = ~clk;

    assign sout = loop_en ? sin_out : sout_drv;

    link_partner #(.CLK_DIV(4)) dut (
        .clk(clk), .nreset(nreset), .sck_dir(sck_dir), .sck_in(sck_in), .sout(sout),
        .sck_out(sck_out), .sin_out(sin_out), .tx_byte(tx_byte), .tx_load(tx_load),
        .start(start), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy)
    );

    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (rx_valid) rxv_cnt++;
        if (sck_prev && !sck_out) sck_falls++;
        sck_prev = sck_out;
    end

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(input logic [7:0] val, input bit do_load);
        @(negedge clk);
        tx_byte = val;
        tx_load = do_load;
        start   = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset;
        nreset = 1'b0; sck_dir = 1'b0; sck_in = 1'b1; sout_drv = 1'b1; loop_en = 1'b0;
        tx_load = 1'b0; start = 1'b0; tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (sck_out !== 1'b1) begin errors++; $display("FAIL reset_sck_out got %b want 1", sck_out); end
        checks++; if (sin_out !== 1'b1) begin errors++; $display("FAIL reset_sin_out got %b want 1", sin_out); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want 00", rx_byte); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        nreset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_slave;
        logic [7:0] dmg_val, exp_tx;
        int r0;
        dmg_val = 8'h3C;
        exp_tx  = 8'hA5;
        @(negedge clk); tx_byte = 8'hA5; tx_load = 1'b1;
        @(negedge clk); tx_load = 1'b0; sck_dir = 1'b1;
        repeat (4) @(negedge clk);
        r0 = rxv_cnt;
        for (int i = 7; i >= 0; i--) begin
            sck_in = 1'b0; sout_drv = dmg_val[i];
            repeat (8) @(negedge clk);
            checks++;
            if (sin_out !== exp_tx[i]) begin
                errors++; $display("FAIL slave_sin_bit%0d got %b want %b", 7 - i, sin_out, exp_tx[i]);
            end
            sck_in = 1'b1;
            repeat (8) @(negedge clk);
        end
        checks++; if (rx_byte !== 8'h3C) begin errors++; $display("FAIL slave_rx_byte got %h want 3c", rx_byte); end
        checks++; if (rxv_cnt - r0 !== 1) begin errors++; $display("FAIL slave_rx_valid_pulses got %0d want 1", rxv_cnt - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL slave_busy_end got %b want 0", busy); end
        checks++; if (sin_out !== 1'b1) begin errors++; $display("FAIL slave_sin_idle got %b want 1", sin_out); end
        sck_dir = 1'b0; sout_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_master;
        int b0, f0, r0;
        bit ok;
        loop_en = 1'b1;
        @(negedge clk); tx_byte = 8'h81; tx_load = 1'b1;
        @(negedge clk); tx_load = 1'b0;
        b0 = busy_cycles; f0 = sck_falls; r0 = rxv_cnt;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL master_busy_start got %b want 1", busy); end
        checks++; if (sck_out !== 1'b0) begin errors++; $display("FAIL master_sck_low got %b want 0", sck_out); end
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL master_timeout got busy=%b want idle", busy); end
        @(negedge clk); #1;
        checks++; if (rx_byte !== 8'h81) begin errors++; $display("FAIL master_rx_byte got %h want 81", rx_byte); end
        checks++; if (busy_cycles - b0 !== 64) begin errors++; $display("FAIL master_busy_cycles got %0d want 64", busy_cycles - b0); end
        checks++; if (sck_falls - f0 !== 8) begin errors++; $display("FAIL master_sck_periods got %0d want 8", sck_falls - f0); end
        checks++; if (rxv_cnt - r0 !== 1) begin errors++; $display("FAIL master_rx_valid_pulses got %0d want 1", rxv_cnt - r0); end
        checks++; if (sck_out !== 1'b1) begin errors++; $display("FAIL master_sck_idle got %b want 1", sck_out); end
    endtask

    task automatic test_tx_load_mid;
        bit ok;
        pulse_start(8'hF0, 1'b1);
        repeat (20) @(negedge clk);
        tx_byte = 8'h55; tx_load = 1'b1;
        @(negedge clk); tx_load = 1'b0;
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL txmid_timeout1 got busy=%b want idle", busy); end
        checks++; if (rx_byte !== 8'hF0) begin errors++; $display("FAIL txmid_current got %h want f0", rx_byte); end
        pulse_start(8'h00, 1'b0);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL txmid_timeout2 got busy=%b want idle", busy); end
        checks++; if (rx_byte !== 8'h55) begin errors++; $display("FAIL txmid_next got %h want 55", rx_byte); end
        pulse_start(8'h3C, 1'b1);
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL txcoincide_timeout got busy=%b want idle", busy); end
        checks++; if (rx_byte !== 8'h3C) begin errors++; $display("FAIL txcoincide_rx got %h want 3c", rx_byte); end
    endtask

    task automatic test_abort;
        int r0;
        r0 = rxv_cnt;
        pulse_start(8'h0F, 1'b1);
        repeat (26) @(negedge clk);
        sck_dir = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (sck_out !== 1'b1) begin errors++; $display("FAIL abort_sck_out got %b want 1", sck_out); end
        checks++; if (sin_out !== 1'b1) begin errors++; $display("FAIL abort_sin_out got %b want 1", sin_out); end
        checks++; if (rx_byte !== 8'h3C) begin errors++; $display("FAIL abort_rx_byte got %h want 3c", rx_byte); end
        checks++; if (rxv_cnt - r0 !== 0) begin errors++; $display("FAIL abort_rx_valid got %0d want 0", rxv_cnt - r0); end
        sck_dir = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int r0, f0;
        bit ok;
        r0 = rxv_cnt;
        pulse_start(8'h99, 1'b1);
        repeat (42) @(negedge clk);
        nreset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (sck_out !== 1'b1) begin errors++; $display("FAIL rstmid_sck_out got %b want 1", sck_out); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_rx_byte got %h want 00", rx_byte); end
        @(negedge clk); nreset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rxv_cnt - r0 !== 0) begin errors++; $display("FAIL rstmid_rx_valid got %0d want 0", rxv_cnt - r0); end
        f0 = sck_falls; r0 = rxv_cnt;
        pulse_start(8'h00, 1'b0);
        wait_idle(200, ok);
        @(negedge clk); #1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_timeout got busy=%b want idle", busy); end
        checks++; if (rx_byte !== 8'hFF) begin errors++; $display("FAIL rstmid_next_rx got %h want ff", rx_byte); end
        checks++; if (sck_falls - f0 !== 8) begin errors++; $display("FAIL rstmid_next_periods got %0d want 8", sck_falls - f0); end
        checks++; if (rxv_cnt - r0 !== 1) begin errors++; $display("FAIL rstmid_next_valid got %0d want 1", rxv_cnt - r0); end
    endtask

    task automatic test_start_busy;
        int f0, r0, f1;
        bit ok;
        f0 = sck_falls; r0 = rxv_cnt;
        pulse_start(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_idle(200, ok);
        @(negedge clk); #1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL startbusy_timeout got busy=%b want idle", busy); end
        checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL startbusy_rx got %h want a5", rx_byte); end
        checks++; if (sck_falls - f0 !== 8) begin errors++; $display("FAIL startbusy_periods got %0d want 8", sck_falls - f0); end
        checks++; if (rxv_cnt - r0 !== 1) begin errors++; $display("FAIL startbusy_valid got %0d want 1", rxv_cnt - r0); end
        f1 = sck_falls;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startbusy_no_restart got busy=%b want 0", busy); end
        checks++; if (sck_falls - f1 !== 0) begin errors++; $display("FAIL startbusy_extra_sck got %0d want 0", sck_falls - f1); end
    endtask

    initial begin
        test_reset();
        test_slave();
        test_master();
        test_tx_load_mid();
        test_abort();
        test_reset_mid();
        test_start_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
